stb_drain_unit: RTL and testbench

//  Parametrised store buffer with integrated drain controller, between LSU and dcache.

---
 rtl/stb_pkg.sv | 22 ++
 rtl/stb_fwd_lookup.sv | 54 +++++
 rtl/stb_drain_unit.sv | 151 +++++++++++++++
 tb/tb_stb_drain_unit.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stb_pkg.sv
// Store buffer shared types.
//  stb_state_e : drain controller states
//  stb_entry_t : one buffered store at the default 32-bit address/data geometry
//  cnt_w()     : width of an occupancy counter able to hold 0..depth
package stb_pkg;

  typedef enum logic [0:0] {IDLE, WRITE} stb_state_e;

  localparam int unsigned STB_ADDR_W = 32;
  localparam int unsigned STB_DATA_W = 32;

  typedef struct packed {
    logic [STB_ADDR_W-1:0]   addr;
    logic [STB_DATA_W-1:0]   data;
    logic [STB_DATA_W/8-1:0] sel;
  } stb_entry_t;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stb_fwd_lookup.sv
// Youngest-match search of the store buffer for a load.
//  ent_addr/ent_data/ent_sel : entry array, indexed by physical slot
//  rd_ptr, count             : oldest slot and number of valid entries
//  ld_addr, ld_sel           : load word address and byte mask
//  fwd_hit/fwd_data          : youngest match covers every load byte, and its data
//  ld_stall                  : youngest match exists but misses some load bytes
module stb_fwd_lookup #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SEL_W  = DATA_W / 8,
  parameter int unsigned PTR_W  = $clog2(DEPTH),
  parameter int unsigned CNT_W  = PTR_W + 1
) (
  input  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0] ent_data,
  input  logic [DEPTH-1:0][SEL_W-1:0]  ent_sel,
  input  logic [PTR_W-1:0]             rd_ptr,
  input  logic [CNT_W-1:0]             count,
  input  logic [ADDR_W-1:0]            ld_addr,
  input  logic [SEL_W-1:0]             ld_sel,
  output logic                         fwd_hit,
  output logic [DATA_W-1:0]            fwd_data,
  output logic                         ld_stall
);

  logic              match_any;
  logic [SEL_W-1:0]  match_sel;
  logic [DATA_W-1:0] match_data;
  logic [PTR_W-1:0]  idx;
  logic              covered;

  always_comb begin
    match_any  = 1'b0;
    match_sel  = '0;
    match_data = '0;
    idx        = '0;
    // Walk oldest to youngest so the last match found is the youngest store.
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < count) && (ent_addr[idx][ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
        match_any  = 1'b1;
        match_sel  = ent_sel[idx];
        match_data = ent_data[idx];
      end
    end
  end

  assign covered  = ((match_sel & ld_sel) == ld_sel);
  assign fwd_hit  = match_any & covered;
  assign ld_stall = match_any & ~covered;
  assign fwd_data = fwd_hit ? match_data : '0;

endmodule

// File: rtl/stb_drain_unit.sv
// Store buffer with integrated drain controller between LSU and dcache.
//  LSU push  : lsu2stb_req/addr/wdata/sel -> stb2lsu_ack
//  LSU load  : lsu2stb_ld_addr/ld_sel -> stb2lsu_fwd_hit/fwd_data/ld_stall
//  Fence     : lsu2stb_flush -> stb2lsu_flush_done (one-cycle pulse)
//  Dcache    : stb2dcache_req/addr/wdata/sel/w_en <- dcache2stb_ack
//  Status    : stb_full, stb_empty, stb_count
module stb_drain_unit
  import stb_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned DRAIN_THRESH = 1,
  parameter int unsigned IDLE_TIMEOUT = 16,
  localparam int unsigned SEL_W       = DATA_W / 8,
  localparam int unsigned CNT_W       = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lsu2stb_req,
  input  logic [ADDR_W-1:0] lsu2stb_addr,
  input  logic [DATA_W-1:0] lsu2stb_wdata,
  input  logic [SEL_W-1:0]  lsu2stb_sel,
  output logic              stb2lsu_ack,
  input  logic [ADDR_W-1:0] lsu2stb_ld_addr,
  input  logic [SEL_W-1:0]  lsu2stb_ld_sel,
  output logic              stb2lsu_fwd_hit,
  output logic [DATA_W-1:0] stb2lsu_fwd_data,
  output logic              stb2lsu_ld_stall,
  input  logic              lsu2stb_flush,
  output logic              stb2lsu_flush_done,
  output logic              stb2dcache_req,
  output logic [ADDR_W-1:0] stb2dcache_addr,
  output logic [DATA_W-1:0] stb2dcache_wdata,
  output logic [SEL_W-1:0]  stb2dcache_sel,
  output logic              stb2dcache_w_en,
  input  logic              dcache2stb_ack,
  output logic              stb_full,
  output logic              stb_empty,
  output logic [CNT_W-1:0]  stb_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned TMO_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] THRESH_CNT = CNT_W'(DRAIN_THRESH);
  localparam logic [TMO_W-1:0] TMO_MAX    = TMO_W'(IDLE_TIMEOUT);

  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [DEPTH-1:0][SEL_W-1:0]  sel_q;
  logic [PTR_W-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [TMO_W-1:0]             tmo_q;
  logic                         flush_pend_q, flush_done_q;
  stb_state_e                   state_q;

  logic push, pop, drain_go, keep_going, flush_hit;

  assign stb_full  = (count_q == FULL_CNT);
  assign stb_empty = (count_q == '0);
  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign push      = lsu2stb_req & ~stb_full;
  assign pop       = (state_q == WRITE) & dcache2stb_ack;
  assign count_d   = count_q + CNT_W'(push) - CNT_W'(pop);

  assign drain_go = ~stb_empty & ((count_q >= THRESH_CNT) | flush_pend_q |
                                  ((IDLE_TIMEOUT != 0) & (tmo_q == TMO_MAX)));

  // Continue draining after an ack only while the reason to drain still holds.
  assign keep_going = (count_d != '0) &
                      (flush_pend_q | (count_d >= THRESH_CNT) |
                       ((IDLE_TIMEOUT == 0) & (DRAIN_THRESH == 1)));

  // A flush seen while already empty completes immediately.
  assign flush_hit = (flush_pend_q | lsu2stb_flush) & stb_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      tmo_q        <= '0;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
      state_q      <= IDLE;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q      <= count_d;
      flush_done_q <= flush_hit;
      flush_pend_q <= flush_hit ? 1'b0 : (flush_pend_q | lsu2stb_flush);
      unique case (state_q)
        IDLE: begin
          if (drain_go) begin
            state_q <= WRITE;
            tmo_q   <= '0;
          end else if (stb_empty) begin
            tmo_q <= '0;
          end else if (tmo_q != TMO_MAX) begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        WRITE: begin
          tmo_q <= '0;
          if (pop && !keep_going) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Entry storage needs no reset: validity is derived from rd_ptr/count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= lsu2stb_addr;
      data_q[wr_ptr_q] <= lsu2stb_wdata;
      sel_q[wr_ptr_q]  <= lsu2stb_sel;
    end
  end

  stb_fwd_lookup #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W),
    .PTR_W  (PTR_W),
    .CNT_W  (CNT_W)
  ) u_fwd_lookup (
    .ent_addr (addr_q),
    .ent_data (data_q),
    .ent_sel  (sel_q),
    .rd_ptr   (rd_ptr_q),
    .count    (count_q),
    .ld_addr  (lsu2stb_ld_addr),
    .ld_sel   (lsu2stb_ld_sel),
    .fwd_hit  (stb2lsu_fwd_hit),
    .fwd_data (stb2lsu_fwd_data),
    .ld_stall (stb2lsu_ld_stall)
  );

  assign stb2lsu_ack        = push;
  assign stb2lsu_flush_done = flush_done_q;
  assign stb_count          = count_q;
  assign stb2dcache_req     = (state_q == WRITE);
  assign stb2dcache_w_en    = stb2dcache_req;
  assign stb2dcache_addr    = stb2dcache_req ? addr_q[rd_ptr_q] : '0;
  assign stb2dcache_wdata   = stb2dcache_req ? data_q[rd_ptr_q] : '0;
  assign stb2dcache_sel     = stb2dcache_req ? sel_q[rd_ptr_q]  : '0;

endmodule

// File: tb/tb_stb_drain_unit.sv
module tb_stb_drain_unit;
  import stb_pkg::*;

  localparam int DEPTH = 8;
  localparam int TH    = 4;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu2stb_req = 1'b0;
  logic [31:0] lsu2stb_addr = '0;
  logic [31:0] lsu2stb_wdata = '0;
  logic [3:0]  lsu2stb_sel = '0;
  logic        stb2lsu_ack;
  logic [31:0] lsu2stb_ld_addr = '0;
  logic [3:0]  lsu2stb_ld_sel = '0;
  logic        stb2lsu_fwd_hit;
  logic [31:0] stb2lsu_fwd_data;
  logic        stb2lsu_ld_stall;
  logic        lsu2stb_flush = 1'b0;
  logic        stb2lsu_flush_done;
  logic        stb2dcache_req;
  logic [31:0] stb2dcache_addr;
  logic [31:0] stb2dcache_wdata;
  logic [3:0]  stb2dcache_sel;
  logic        stb2dcache_w_en;
  logic        dcache2stb_ack = 1'b0;
  logic        stb_full;
  logic        stb_empty;
  logic [3:0]  stb_count;

  always #5 clk = ~clk;

  stb_drain_unit #(
    .DEPTH        (DEPTH),
    .ADDR_W       (32),
    .DATA_W       (32),
    .DRAIN_THRESH (TH),
    .IDLE_TIMEOUT (TMO)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .lsu2stb_req        (lsu2stb_req),
    .lsu2stb_addr       (lsu2stb_addr),
    .lsu2stb_wdata      (lsu2stb_wdata),
    .lsu2stb_sel        (lsu2stb_sel),
    .stb2lsu_ack        (stb2lsu_ack),
    .lsu2stb_ld_addr    (lsu2stb_ld_addr),
    .lsu2stb_ld_sel     (lsu2stb_ld_sel),
    .stb2lsu_fwd_hit    (stb2lsu_fwd_hit),
    .stb2lsu_fwd_data   (stb2lsu_fwd_data),
    .stb2lsu_ld_stall   (stb2lsu_ld_stall),
    .lsu2stb_flush      (lsu2stb_flush),
    .stb2lsu_flush_done (stb2lsu_flush_done),
    .stb2dcache_req     (stb2dcache_req),
    .stb2dcache_addr    (stb2dcache_addr),
    .stb2dcache_wdata   (stb2dcache_wdata),
    .stb2dcache_sel     (stb2dcache_sel),
    .stb2dcache_w_en    (stb2dcache_w_en),
    .dcache2stb_ack     (dcache2stb_ack),
    .stb_full           (stb_full),
    .stb_empty          (stb_empty),
    .stb_count          (stb_count)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: FIFO queue plus drain/timeout/flush bookkeeping.
  stb_entry_t mq[$];
  bit m_wr, m_pend, m_done;
  int m_tmo;

  // Values sampled from the DUT in the most recent cycle.
  logic        s_ack, s_req, s_wen, s_full, s_empty, s_done, s_hit, s_stall;
  logic [31:0] s_addr, s_wdata, s_fdata;
  logic [3:0]  s_sel, s_count;

  task automatic model_clear();
    mq.delete();
    m_wr = 0; m_pend = 0; m_done = 0; m_tmo = 0;
  endtask

  task automatic model_check();
    int n = mq.size();
    bit found = 0;
    bit e_hit = 0;
    bit e_stall = 0;
    logic [31:0] e_fdata = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!found && mq[i].addr[31:2] == lsu2stb_ld_addr[31:2]) begin
        found = 1;
        if ((mq[i].sel & lsu2stb_ld_sel) == lsu2stb_ld_sel) begin
          e_hit = 1;
          e_fdata = mq[i].data;
        end else begin
          e_stall = 1;
        end
      end
    end
    chk("m_ack", s_ack, lsu2stb_req && n < DEPTH);
    chk("m_count", s_count, n);
    chk("m_full", s_full, n == DEPTH);
    chk("m_empty", s_empty, n == 0);
    chk("m_req", s_req, m_wr);
    chk("m_wen", s_wen, m_wr);
    chk("m_flush_done", s_done, m_done);
    chk("m_fwd_hit", s_hit, e_hit);
    chk("m_ld_stall", s_stall, e_stall);
    if (e_hit) chk("m_fwd_data", s_fdata, e_fdata);
    if (m_wr && n > 0) begin
      chk("m_dc_addr", s_addr, mq[0].addr);
      chk("m_dc_wdata", s_wdata, mq[0].data);
      chk("m_dc_sel", s_sel, mq[0].sel);
    end
  endtask

  task automatic model_update();
    int n = mq.size();
    bit push = lsu2stb_req && n < DEPTH;
    bit pop = m_wr && dcache2stb_ack;
    bit go = n > 0 && (n >= TH || m_pend || m_tmo == TMO);
    bit fl_done = (m_pend || lsu2stb_flush) && n == 0;
    stb_entry_t e;
    if (pop) void'(mq.pop_front());
    if (push) begin
      e.addr = lsu2stb_addr;
      e.data = lsu2stb_wdata;
      e.sel  = lsu2stb_sel;
      mq.push_back(e);
    end
    if (!m_wr) begin
      m_tmo = (go || n == 0) ? 0 : ((m_tmo < TMO) ? m_tmo + 1 : m_tmo);
      m_wr = go;
    end else begin
      m_tmo = 0;
      if (pop) m_wr = mq.size() > 0 && (m_pend || mq.size() >= TH);
    end
    m_done = fl_done;
    m_pend = fl_done ? 0 : (m_pend || lsu2stb_flush);
  endtask

  task automatic sample();
    s_ack = stb2lsu_ack; s_req = stb2dcache_req; s_wen = stb2dcache_w_en;
    s_full = stb_full; s_empty = stb_empty; s_done = stb2lsu_flush_done;
    s_hit = stb2lsu_fwd_hit; s_stall = stb2lsu_ld_stall; s_addr = stb2dcache_addr;
    s_wdata = stb2dcache_wdata; s_fdata = stb2lsu_fwd_data; s_sel = stb2dcache_sel;
    s_count = stb_count;
  endtask

  // Inputs are driven 1 time unit after posedge; outputs sampled on negedge.
  task automatic cycle();
    @(negedge clk);
    sample();
    model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    lsu2stb_req = 0; lsu2stb_flush = 0; dcache2stb_ack = 0;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    lsu2stb_req = 1; lsu2stb_addr = a; lsu2stb_wdata = d; lsu2stb_sel = s;
  endtask

  // Wait (bounded) for a dcache request, then ack it and check the written address.
  task automatic drain_one(input string nm, input logic [31:0] exp_addr, input int bound);
    bit seen = 0;
    dcache2stb_ack = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      cycle();
      seen = s_req;
    end
    chk({nm, "_req_seen"}, seen, 1);
    if (seen) begin
      dcache2stb_ack = 1;
      cycle();
      chk({nm, "_addr"}, s_addr, exp_addr);
    end
    dcache2stb_ack = 0;
  endtask

  typedef struct {
    logic [31:0] ld_addr;
    logic [3:0]  ld_sel;
    bit          hit;
    bit          stall;
    logic [31:0] data;
  } fwd_vec_t;

  fwd_vec_t fv[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int wait_cnt;
    int done_cnt;
    int wr_n;
    bit seen;
    logic [31:0] wr_addr[2];

    fv[0] = '{32'h200, 4'h3, 1, 0, 32'hBBBB_BBBB};
    fv[1] = '{32'h200, 4'hC, 0, 1, 32'h0};
    fv[2] = '{32'h204, 4'hF, 0, 0, 32'h0};
    fv[3] = '{32'h202, 4'h1, 1, 0, 32'hBBBB_BBBB};
    fv[4] = '{32'h300, 4'hF, 1, 0, 32'hCCCC_CCCC};
    fv[5] = '{32'h200, 4'hF, 0, 1, 32'h0};
    fv[6] = '{32'h30C, 4'h6, 1, 0, 32'hD000_0005};
    fv[7] = '{32'h318, 4'hF, 0, 0, 32'h0};

    // Reset values.
    model_clear();
    @(posedge clk);
    #1;
    chk("rst_req", stb2dcache_req, 0);
    chk("rst_empty", stb_empty, 1);
    chk("rst_count", stb_count, 0);
    chk("rst_full", stb_full, 0);
    chk("rst_flush_done", stb2lsu_flush_done, 0);
    rst_n = 1;

    // Threshold: three stores do not start a drain, the fourth does.
    for (int k = 0; k < 3; k++) begin
      push(32'h100 + 32'(4 * k), 32'h1000 + 32'(k), 4'hF);
      cycle();
    end
    idle_in();
    cycle();
    chk("thr_no_req_3", s_req, 0);
    chk("thr_count_3", s_count, 3);
    push(32'h10C, 32'h1003, 4'hF);
    cycle();
    idle_in();
    cycle();
    chk("thr_req_next", s_req, 0);
    cycle();
    chk("thr_req_4", s_req, 1);
    for (int k = 0; k < 4; k++) drain_one("fifo", 32'h100 + 32'(4 * k), 40);
    cycle();
    chk("fifo_empty", s_empty, 1);

    // Fill to full with the drain stalled, then forwarding table.
    push(32'h200, 32'hAAAA_AAAA, 4'hF); cycle();
    push(32'h200, 32'hBBBB_BBBB, 4'h3); cycle();
    push(32'h300, 32'hCCCC_CCCC, 4'hF); cycle();
    for (int k = 3; k < 8; k++) begin
      push(32'h300 + 32'(4 * (k - 2)), 32'hD000_0000 + 32'(k), 4'hF);
      cycle();
    end
    idle_in();
    cycle();
    chk("full_flag", s_full, 1);
    chk("full_count", s_count, 8);
    for (int i = 0; i < 8; i++) begin
      lsu2stb_ld_addr = fv[i].ld_addr;
      lsu2stb_ld_sel  = fv[i].ld_sel;
      cycle();
      chk($sformatf("fwd%0d_hit", i), s_hit, fv[i].hit);
      chk($sformatf("fwd%0d_stall", i), s_stall, fv[i].stall);
      if (fv[i].hit) chk($sformatf("fwd%0d_data", i), s_fdata, fv[i].data);
    end
    push(32'h318, 32'h9, 4'hF);
    cycle();
    chk("full_push_refused", s_ack, 0);
    push(32'h31C, 32'hA, 4'hF);
    dcache2stb_ack = 1;
    cycle();
    chk("full_ackpush_refused", s_ack, 0);
    chk("full_ackpush_req", s_req, 1);
    idle_in();
    cycle();
    chk("full_after_pop", s_count, 7);
    dcache2stb_ack = 1;
    for (int i = 0; i < 200 && !s_empty; i++) cycle();
    chk("full_drained", s_empty, 1);
    idle_in();

    // Idle timeout: a single store is written after the counter expires.
    push(32'h500, 32'h5, 4'hF);
    cycle();
    idle_in();
    n = 0;
    seen = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      cycle();
      n = i;
      seen = s_req;
    end
    // Counter walks 0..16 over 17 idle cycles; req is registered one cycle later.
    chk("tmo_latency", n, 18);
    dcache2stb_ack = 1;
    cycle();
    idle_in();
    cycle();
    chk("tmo_drained", s_empty, 1);

    // Flush with two entries and a 3-cycle ack delay.
    push(32'h600, 32'h6, 4'hF); cycle();
    push(32'h604, 32'h7, 4'hF); cycle();
    idle_in();
    lsu2stb_flush = 1;
    cycle();
    lsu2stb_flush = 0;
    wait_cnt = 0; done_cnt = 0; wr_n = 0;
    for (int i = 0; i < 30; i++) begin
      dcache2stb_ack = (wait_cnt == 3);
      cycle();
      if (s_req) begin
        if (dcache2stb_ack) begin
          if (wr_n < 2) wr_addr[wr_n] = s_addr;
          wr_n++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
      if (s_done) begin
        done_cnt++;
        chk("flush_done_empty", s_empty, 1);
      end
    end
    idle_in();
    chk("flush_writes", wr_n, 2);
    if (wr_n >= 2) begin
      chk("flush_addr0", wr_addr[0], 32'h600);
      chk("flush_addr1", wr_addr[1], 32'h604);
    end
    chk("flush_done_pulses", done_cnt, 1);

    // Flush while already empty completes on the next cycle.
    lsu2stb_flush = 1;
    cycle();
    lsu2stb_flush = 0;
    cycle();
    chk("flush_empty_done", s_done, 1);
    cycle();
    chk("flush_empty_pulse", s_done, 0);

    // Asynchronous reset in the middle of a write.
    for (int k = 0; k < 3; k++) begin
      push(32'h700 + 32'(4 * k), 32'h70 + 32'(k), 4'hF);
      cycle();
    end
    idle_in();
    lsu2stb_flush = 1;
    cycle();
    lsu2stb_flush = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      seen = s_req;
    end
    chk("rstw_req_before", seen, 1);
    #2;
    rst_n = 0;
    #1;
    chk("rstw_req", stb2dcache_req, 0);
    chk("rstw_empty", stb_empty, 1);
    chk("rstw_count", stb_count, 0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1;
    push(32'h800, 32'h8, 4'hF);
    cycle();
    chk("rstw_push_ack", s_ack, 1);
    idle_in();
    cycle();
    chk("rstw_push_count", s_count, 1);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      lsu2stb_req     = ($urandom % 2) == 0;
      lsu2stb_addr    = 32'h400 + 32'(($urandom % 6) * 4) + 32'($urandom % 4);
      lsu2stb_wdata   = $urandom;
      lsu2stb_sel     = 4'($urandom % 16);
      lsu2stb_ld_addr = 32'h400 + 32'(($urandom % 6) * 4);
      lsu2stb_ld_sel  = 4'($urandom % 16);
      dcache2stb_ack  = ($urandom % 3) != 0;
      lsu2stb_flush   = ($urandom % 40) == 0;
      cycle();
    end
    idle_in();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
